// File: rtl/ls_store_buffer.sv
// rtl/ls_store_buffer.sv - load/store unit store buffer with in-order commit and drain
//
// Purpose:
//   Holds speculative stores in a circular FIFO until the ROB retires them,
//   then drains committed stores to data memory one per cycle. Loads read
//   memory directly. A load that overlaps a buffered store is either
//   forwarded or stalled.
//
// Configuration:
//   SB_FWD_EN (macro) - when defined, a load whose address exactly matches
//                       the youngest overlapping store returns that store's
//                       data; otherwise any overlap stalls the load.
//
// Ports:
//   in_clk, in_rst                 - clock, synchronous active-high reset
//   in_req_*                       - LS request (store/load, addr, data, ROB index)
//   out_req_ready                  - request accepted this edge when high with valid
//   in_commit_valid/_rob_index     - ROB retires the store with this index
//   in_flush                       - squash all uncommitted stores
//   out_mem_wen/_waddr/_wval       - drain write port, in_mem_wready accepts
//   out_mem_raddr, in_mem_rdata    - combinational load read port
//   out_rob_done/_dst_rob_index/_value - completion report, one cycle after accept

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

module ls_store_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 14
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_req_valid,
  input  logic                     in_req_is_store,
  input  logic [`GPR_SIZE-1:0]     in_req_addr,
  input  logic [`GPR_SIZE-1:0]     in_req_wval,
  input  logic [`ROB_IDX_SIZE-1:0] in_req_rob_index,
  output logic                     out_req_ready,
  input  logic                     in_commit_valid,
  input  logic [`ROB_IDX_SIZE-1:0] in_commit_rob_index,
  input  logic                     in_flush,
  output logic                     out_mem_wen,
  output logic [ADDR_W-1:0]        out_mem_waddr,
  output logic [`GPR_SIZE-1:0]     out_mem_wval,
  input  logic                     in_mem_wready,
  output logic [ADDR_W-1:0]        out_mem_raddr,
  input  logic [`GPR_SIZE-1:0]     in_mem_rdata,
  output logic                     out_rob_done,
  output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [`GPR_SIZE-1:0]     out_rob_value
);

  localparam int GW = `GPR_SIZE;
  localparam int RW = `ROB_IDX_SIZE;
  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CW = PW + 1;

`ifdef SB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    E_FREE      = 2'd0,
    E_PENDING   = 2'd1,
    E_COMMITTED = 2'd2
  } ent_state_e;

  // Entry payload (no reset needed: validity comes from head/count)
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [GW-1:0]     wval_q [SB_DEPTH];
  logic [RW-1:0]     rob_q  [SB_DEPTH];

  // FIFO bookkeeping. Commits happen in order at the oldest pending entry,
  // so committed entries always form a prefix starting at head: the number
  // of committed entries (ccnt) fully describes the PENDING/COMMITTED split.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;

  logic          done_q;
  logic [RW-1:0] done_rob_q;
  logic [GW-1:0] done_val_q;

  // Derived per-entry state
  logic [PW-1:0] ent_off  [SB_DEPTH];
  ent_state_e    ent_state [SB_DEPTH];

  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      ent_off[i] = PW'(i) - head_q;
      if ({1'b0, ent_off[i]} < ccnt_q) begin
        ent_state[i] = E_COMMITTED;
      end else if ({1'b0, ent_off[i]} < cnt_q) begin
        ent_state[i] = E_PENDING;
      end else begin
        ent_state[i] = E_FREE;
      end
    end
  end

  // Two 8-byte windows intersect when the start addresses differ by less
  // than 8 in either direction (modulo the truncated address space).
  function automatic logic win_overlap(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] d_ab;
    logic [ADDR_W-1:0] d_ba;
    d_ab = a - b;
    d_ba = b - a;
    return (d_ab < ADDR_W'(8)) || (d_ba < ADDR_W'(8));
  endfunction

  logic [ADDR_W-1:0] req_addr;
  logic              ld_req;
  logic [PW-1:0]     scan_idx [SB_DEPTH];
  logic              ovl_any;
  logic              yng_exact;
  logic [GW-1:0]     yng_val;

  assign req_addr      = in_req_addr[ADDR_W-1:0];
  assign ld_req        = in_req_valid && !in_req_is_store;
  assign out_mem_raddr = req_addr;

  // Scan oldest to youngest so the last overlapping hit is the youngest.
  always_comb begin
    ovl_any   = 1'b0;
    yng_exact = 1'b0;
    yng_val   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx[k] = head_q + PW'(k);
      if ((ent_state[scan_idx[k]] != E_FREE) &&
          win_overlap(req_addr, addr_q[scan_idx[k]])) begin
        ovl_any   = 1'b1;
        yng_exact = (addr_q[scan_idx[k]] == req_addr);
        yng_val   = wval_q[scan_idx[k]];
      end
    end
  end

  logic          ld_hazard;
  logic          ld_fwd;
  logic [GW-1:0] ld_value;
  logic          full;
  logic          ready_raw;
  logic          acc;
  logic          st_acc;

  assign ld_fwd    = ld_req && ovl_any && FWD_EN && yng_exact;
  assign ld_hazard = ld_req && ovl_any && !(FWD_EN && yng_exact);
  assign ld_value  = ld_fwd ? yng_val : in_mem_rdata;

  // Ready is computed from the registered count, so a drain in the same
  // cycle does not make room for a store offered to a full buffer.
  assign full      = (cnt_q == CW'(SB_DEPTH));
  assign ready_raw = !in_flush && !(in_req_valid && in_req_is_store && full) && !ld_hazard;
  assign out_req_ready = in_rst ? 1'b1 : ready_raw;
  assign acc       = in_req_valid && ready_raw && !in_rst;
  assign st_acc    = acc && in_req_is_store;

  // Drain port
  logic has_commit;
  logic drain;

  assign has_commit    = (ccnt_q != '0);
  assign out_mem_wen   = has_commit && !in_rst;
  assign out_mem_waddr = out_mem_wen ? addr_q[head_q] : '0;
  assign out_mem_wval  = out_mem_wen ? wval_q[head_q] : '0;
  assign drain         = has_commit && in_mem_wready;

  // Commit only matches the oldest pending entry.
  logic [PW-1:0] pend_idx;
  logic          commit_ok;

  assign pend_idx  = head_q + ccnt_q[PW-1:0];
  assign commit_ok = in_commit_valid && (ccnt_q < cnt_q) &&
                     (rob_q[pend_idx] == in_commit_rob_index);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ccnt_d = ccnt_q + CW'(commit_ok) - CW'(drain);
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    if (in_flush) begin
      // Commit is applied first, then everything younger than the
      // committed prefix is discarded by pulling tail back onto it.
      cnt_d  = ccnt_d;
      tail_d = head_d + ccnt_d[PW-1:0];
    end else begin
      cnt_d  = cnt_q + CW'(st_acc) - CW'(drain);
      tail_d = tail_q + PW'(st_acc);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      ccnt_q     <= '0;
      done_q     <= 1'b0;
      done_rob_q <= '0;
      done_val_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ccnt_q <= ccnt_d;
      done_q <= acc;
      if (acc) begin
        done_rob_q <= in_req_rob_index;
        done_val_q <= in_req_is_store ? '0 : ld_value;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (st_acc) begin
      addr_q[tail_q] <= req_addr;
      wval_q[tail_q] <= in_req_wval;
      rob_q[tail_q]  <= in_req_rob_index;
    end
  end

  assign out_rob_done          = done_q;
  assign out_rob_dst_rob_index = done_rob_q;
  assign out_rob_value         = done_val_q;

  // Upper address bits are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^in_req_addr[GW-1:ADDR_W];

endmodule
